// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: default sizing, the per-entry
// record and the dword address compare used by forwarding.
package store_buffer_pkg;

  localparam int unsigned CFG_XLEN     = 32;
  localparam int unsigned CFG_SB_DEPTH = 8;

  // One buffered committed store.
  typedef struct packed {
    logic                valid;
    logic [CFG_XLEN-1:0] addr;
    logic [63:0]         data;
  } store_buffer_entry_t;

  // Two addresses fall in the same dword when everything above bit 2 agrees.
  function automatic logic dword_match(input logic [CFG_XLEN-1:0] a,
                                       input logic [CFG_XLEN-1:0] b);
    return (a[CFG_XLEN-1:3] == b[CFG_XLEN-1:3]);
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Store buffer to dcache write request channel (valid/ready handshake).
interface store_buffer_if #(
  parameter int unsigned XLEN = 32
);

  logic            dcache_req_valid;
  logic [XLEN-1:0] dcache_req_addr;
  logic [63:0]     dcache_req_data;
  logic            dcache_req_ready;

  modport master (
    output dcache_req_valid,
    output dcache_req_addr,
    output dcache_req_data,
    input  dcache_req_ready
  );

  modport slave (
    input  dcache_req_valid,
    input  dcache_req_addr,
    input  dcache_req_data,
    output dcache_req_ready
  );

endinterface

// File: rtl/store_buffer_chk.sv
// Protocol checker for the store buffer: flags stores dropped while full
// and a request valid that disagrees with the empty flag.
module store_buffer_chk (
  input logic clock,
  input logic reset,
  input logic store_en,
  input logic sb_full,
  input logic sb_empty,
  input logic req_valid
);

  int unsigned drop_cnt_r;

  // Count stores the retire stage raised while the buffer was full.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drop_cnt_r <= 32'd0;
    end else if (store_en && sb_full) begin
      drop_cnt_r <= drop_cnt_r + 32'd1;
    end
  end

  // Immediate checks sampled on every active clock edge out of reset.
  always @(posedge clock) begin
    if (reset) begin
      assert (!(store_en && sb_full))
        else $warning("store_buffer_chk: store_en while sb_full, store dropped");
      assert (req_valid == !sb_empty)
        else $error("store_buffer_chk: dcache_req_valid disagrees with sb_empty");
    end
  end

endmodule

// File: rtl/store_buffer_fwd.sv
// Store-to-load forwarding select: the incoming store wins, otherwise the
// youngest valid buffered entry in the same dword as the lookup address.
module store_buffer_fwd
  import store_buffer_pkg::*;
#(
  parameter int unsigned SB_DEPTH = CFG_SB_DEPTH,
  parameter int unsigned XLEN     = CFG_XLEN
) (
  input  store_buffer_entry_t            entries [SB_DEPTH],
  input  logic [$clog2(SB_DEPTH)-1:0]    head,
  input  logic [$clog2(SB_DEPTH)-1:0]    tail,
  input  logic                           in_valid,
  input  logic [XLEN-1:0]                in_addr,
  input  logic [63:0]                    in_data,
  input  logic [XLEN-1:0]                lookup_addr,
  output logic                           hit,
  output logic [63:0]                    data
);

  localparam int unsigned PTR_W = $clog2(SB_DEPTH);

  logic [PTR_W-1:0] idx_s;
  logic             done_s;

  // Scan from the youngest slot (tail-1) back to head; first match wins.
  always_comb begin
    hit    = 1'b0;
    data   = 64'd0;
    done_s = 1'b0;
    idx_s  = tail;
    if (in_valid && dword_match(in_addr, lookup_addr)) begin
      hit  = 1'b1;
      data = in_data;
    end else begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        idx_s = tail - PTR_W'(1) - PTR_W'(i);
        if (!hit && !done_s && entries[idx_s].valid &&
            dword_match(entries[idx_s].addr, lookup_addr)) begin
          hit  = 1'b1;
          data = entries[idx_s].data;
        end else begin
          data = data;
        end
        if (idx_s == head) begin
          done_s = 1'b1;
        end else begin
          done_s = done_s;
        end
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Committed-store buffer: circular FIFO of dword stores drained in order to
// the dcache, with youngest-match forwarding to loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned SB_DEPTH = CFG_SB_DEPTH,
  parameter int unsigned XLEN     = CFG_XLEN
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 store_en,
  input  logic [XLEN-1:0]      store_addr,
  input  logic [63:0]          store_data,
  output logic                 sb_full,
  output logic                 sb_empty,
  store_buffer_if.master       dcache,
  input  logic [XLEN-1:0]      fwd_addr,
  output logic                 fwd_hit,
  output logic [63:0]          fwd_data,
  output logic [31:0]          stores_issued
);

  localparam int unsigned PTR_W = $clog2(SB_DEPTH);
  localparam int unsigned CNT_W = $clog2(SB_DEPTH + 1);

  store_buffer_entry_t entries_r [SB_DEPTH];
  logic [PTR_W-1:0]    head_r;
  logic [PTR_W-1:0]    tail_r;
  logic [CNT_W-1:0]    count_r;
  logic [CNT_W-1:0]    count_next_s;
  logic                full_r;
  logic                empty_r;
  logic [31:0]         issued_r;
  logic                enq_s;
  logic                deq_s;
  logic [XLEN-1:0]     store_addr_dw_s;

  // Full is taken from the registered count, so a same-cycle dequeue never
  // opens a slot for an enqueue.
  assign enq_s           = store_en && !full_r;
  assign deq_s           = !empty_r && dcache.dcache_req_ready;
  assign store_addr_dw_s = {store_addr[XLEN-1:3], 3'b000};

  // Next occupancy from the enqueue/dequeue pair.
  always_comb begin
    count_next_s = count_r;
    if (enq_s && !deq_s) begin
      count_next_s = count_r + CNT_W'(1);
    end else if (!enq_s && deq_s) begin
      count_next_s = count_r - CNT_W'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Pointers, occupancy, status flags and the issued-store counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_r   <= '0;
      tail_r   <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      issued_r <= 32'd0;
    end else begin
      count_r <= count_next_s;
      full_r  <= (count_next_s == CNT_W'(SB_DEPTH));
      empty_r <= (count_next_s == CNT_W'(0));
      if (enq_s) begin
        tail_r <= tail_r + PTR_W'(1);
      end
      if (deq_s) begin
        head_r   <= head_r + PTR_W'(1);
        issued_r <= issued_r + 32'd1;
      end
    end
  end

  // Entry storage: write at tail on enqueue, retire head on dequeue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        entries_r[i] <= '0;
      end
    end else begin
      if (enq_s) begin
        entries_r[tail_r] <= '{valid: 1'b1, addr: store_addr_dw_s, data: store_data};
      end
      if (deq_s) begin
        entries_r[head_r].valid <= 1'b0;
      end
    end
  end

  // The request is read straight out of head storage; head only moves on a
  // handshake, so the fields hold while the dcache stalls.
  assign dcache.dcache_req_valid = !empty_r;
  assign dcache.dcache_req_addr  = entries_r[head_r].addr;
  assign dcache.dcache_req_data  = entries_r[head_r].data;
  assign sb_full                 = full_r;
  assign sb_empty                = empty_r;
  assign stores_issued           = issued_r;

  store_buffer_fwd #(
    .SB_DEPTH (SB_DEPTH),
    .XLEN     (XLEN)
  ) u_fwd (
    .entries     (entries_r),
    .head        (head_r),
    .tail        (tail_r),
    .in_valid    (enq_s),
    .in_addr     (store_addr_dw_s),
    .in_data     (store_data),
    .lookup_addr (fwd_addr),
    .hit         (fwd_hit),
    .data        (fwd_data)
  );

  store_buffer_chk u_chk (
    .clock     (clock),
    .reset     (reset),
    .store_en  (store_en),
    .sb_full   (full_r),
    .sb_empty  (empty_r),
    .req_valid (!empty_r)
  );

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus a randomized
// phase, all checked against a queue-based reference model.
module tb_store_buffer;

  localparam int unsigned D = 8;

  logic        clock;
  logic        reset;
  logic        store_en;
  logic [31:0] store_addr;
  logic [63:0] store_data;
  logic        sb_full;
  logic        sb_empty;
  logic [31:0] fwd_addr;
  logic        fwd_hit;
  logic [63:0] fwd_data;
  logic [31:0] stores_issued;

  store_buffer_if #(.XLEN(32)) dc_if ();

  store_buffer #(.SB_DEPTH(D), .XLEN(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .store_en      (store_en),
    .store_addr    (store_addr),
    .store_data    (store_data),
    .sb_full       (sb_full),
    .sb_empty      (sb_empty),
    .dcache        (dc_if),
    .fwd_addr      (fwd_addr),
    .fwd_hit       (fwd_hit),
    .fwd_data      (fwd_data),
    .stores_issued (stores_issued)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model: the buffer is a plain queue of aligned {addr,data}.
  typedef struct {
    bit [31:0] a;
    bit [63:0] d;
  } ent_t;

  ent_t        q[$];
  int unsigned exp_issued;
  int unsigned enq_total;
  int          tests;
  int          fails;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Compare every visible output against the model for the current inputs.
  task automatic check_outputs();
    bit        eh;
    bit [63:0] ed;
    eh = 1'b0;
    ed = 64'd0;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].a[31:3] == fwd_addr[31:3]) begin
        eh = 1'b1;
        ed = q[i].d;
      end
    end
    if (store_en && q.size() < D && store_addr[31:3] == fwd_addr[31:3]) begin
      eh = 1'b1;
      ed = store_data;
    end
    chk("sb_empty", 64'(sb_empty), 64'(q.size() == 0));
    chk("sb_full", 64'(sb_full), 64'(q.size() == D));
    chk("req_valid", 64'(dc_if.dcache_req_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("req_addr", 64'(dc_if.dcache_req_addr), 64'(q[0].a));
      chk("req_data", dc_if.dcache_req_data, q[0].d);
    end
    chk("stores_issued", 64'(stores_issued), 64'(exp_issued));
    chk("fwd_hit", 64'(fwd_hit), 64'(eh));
    chk("fwd_data", fwd_data, ed);
  endtask

  // One clock: drive at the falling edge, check, then advance the model.
  task automatic step(input bit en, input bit [31:0] addr, input bit [63:0] data,
                      input bit rdy, input bit [31:0] faddr);
    bit do_enq;
    bit do_deq;
    store_en   = en;
    store_addr = addr;
    store_data = data;
    dc_if.dcache_req_ready = rdy;
    fwd_addr   = faddr;
    #1;
    check_outputs();
    do_enq = en && (q.size() < D);
    do_deq = rdy && (q.size() > 0);
    @(posedge clock);
    if (do_deq) begin
      void'(q.pop_front());
      exp_issued++;
    end
    if (do_enq) begin
      q.push_back('{a: {addr[31:3], 3'b000}, d: data});
      enq_total++;
    end
    @(negedge clock);
  endtask

  initial begin
    bit [31:0] ra;
    bit [31:0] fa;
    bit [31:0] base_issued;
    int        guard;

    tests      = 0;
    fails      = 0;
    exp_issued = 0;
    enq_total  = 0;
    reset      = 1'b0;
    store_en   = 1'b0;
    store_addr = 32'd0;
    store_data = 64'd0;
    fwd_addr   = 32'd0;
    dc_if.dcache_req_ready = 1'b0;

    // Outputs while reset is held.
    #12;
    chk("rst_full", 64'(sb_full), 64'd0);
    chk("rst_empty", 64'(sb_empty), 64'd1);
    chk("rst_valid", 64'(dc_if.dcache_req_valid), 64'd0);
    chk("rst_addr", 64'(dc_if.dcache_req_addr), 64'd0);
    chk("rst_data", dc_if.dcache_req_data, 64'd0);
    chk("rst_issued", 64'(stores_issued), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // Single store with ready high: latency 1 to request, then drained.
    step(1'b1, 32'h1000, 64'hAA, 1'b1, 32'h0);
    chk("s1_valid", 64'(dc_if.dcache_req_valid), 64'd1);
    chk("s1_addr", 64'(dc_if.dcache_req_addr), 64'h1000);
    chk("s1_data", dc_if.dcache_req_data, 64'hAA);
    step(1'b0, 32'h0, 64'h0, 1'b1, 32'h0);
    chk("s1_empty", 64'(sb_empty), 64'd1);
    chk("s1_issued", 64'(stores_issued), 64'd1);

    // Fill to full with ready low, drop a ninth store, then drain in order.
    for (int i = 0; i < D; i++) begin
      step(1'b1, 32'h4000 + 32'(i) * 32'd8, {$urandom, $urandom}, 1'b0, 32'h0);
    end
    chk("f_full", 64'(sb_full), 64'd1);
    step(1'b1, 32'h5000, 64'hDEAD, 1'b0, 32'h5000);
    chk("f_drop_fwd", 64'(fwd_hit), 64'd0);
    chk("f_drop_seen", 64'(dut.u_chk.drop_cnt_r), 64'd1);
    chk("f_still_full", 64'(sb_full), 64'd1);
    for (int i = 0; i < D; i++) begin
      step(1'b0, 32'h0, 64'h0, 1'b1, 32'h4000 + 32'(D - 1) * 32'd8);
    end
    chk("f_drained", 64'(sb_empty), 64'd1);
    chk("f_issued", 64'(stores_issued), 64'(1 + D));

    // Two stores to the same dword: the younger one forwards.
    step(1'b1, 32'h2000, 64'h11, 1'b0, 32'h0);
    step(1'b1, 32'h2004, 64'h22, 1'b0, 32'h0);
    step(1'b0, 32'h0, 64'h0, 1'b0, 32'h2003);
    chk("fw_hit", 64'(fwd_hit), 64'd1);
    chk("fw_data", fwd_data, 64'h22);
    step(1'b1, 32'h2000, 64'h33, 1'b0, 32'h2007);
    chk("fw_incoming", fwd_data, 64'h33);
    step(1'b0, 32'h0, 64'h0, 1'b0, 32'h2008);
    chk("fw_miss_data", fwd_data, 64'h0);

    // Drain, then three buffered entries with a simultaneous enq/deq.
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 64'h0, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h6000 + 32'(i) * 32'd8, 64'(i + 100), 1'b0, 32'h0);
    chk("c3_count", 64'(dut.count_r), 64'd3);
    step(1'b1, 32'h6100, 64'h77, 1'b1, 32'h0);
    chk("c3_count_same", 64'(dut.count_r), 64'd3);

    // Randomized traffic: at least SB_DEPTH*3 stores through, checked each cycle.
    base_issued = exp_issued;
    enq_total   = 0;
    guard       = 0;
    while (enq_total < D * 3 && guard < 2000) begin
      ra = 32'h3000 + 32'($urandom_range(0, 15)) * 32'd8 + 32'($urandom_range(0, 7));
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        fa = q[$urandom_range(0, q.size() - 1)].a | 32'($urandom_range(0, 7));
      end else begin
        fa = 32'h3000 + 32'($urandom_range(0, 15)) * 32'd8;
      end
      step((q.size() < D) && ($urandom_range(0, 3) != 0), ra, {$urandom, $urandom},
           $urandom_range(0, 2) != 0, fa);
      guard++;
    end
    chk("rnd_enq_budget", 64'(enq_total >= D * 3), 64'd1);
    guard = 0;
    while (q.size() > 0 && guard < 64) begin
      step(1'b0, 32'h0, 64'h0, 1'b1, 32'h0);
      guard++;
    end
    chk("rnd_drain_budget", 64'(q.size()), 64'd0);
    chk("rnd_issued_delta", 64'(stores_issued - base_issued), 64'(exp_issued - base_issued));

    // Asynchronous reset while a request is stalled.
    step(1'b1, 32'h7000, 64'h55, 1'b0, 32'h0);
    step(1'b1, 32'h7008, 64'h66, 1'b0, 32'h0);
    #2;
    reset = 1'b0;
    #1;
    q.delete();
    exp_issued = 0;
    chk("ar_valid", 64'(dc_if.dcache_req_valid), 64'd0);
    chk("ar_empty", 64'(sb_empty), 64'd1);
    chk("ar_addr", 64'(dc_if.dcache_req_addr), 64'd0);
    chk("ar_issued", 64'(stores_issued), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 64'h0, 1'b1, 32'h7000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
